// File: rtl/and_32bit.sv
// 32-bit bitwise AND unit for the ALU.
// Rz is the purely combinational Ra & Rb that feeds the result mux.
// Rz_q, valid_q and zero_q are a registered copy of that result for
// pipelined consumers.
// The datapath is split into independent lanes. AND has no cross-bit
// interaction, so each lane computes its own slice of the result and its
// own zero flag. The top level then only has to reduce the lane flags.

module and_lane #(
    parameter int LANE_W = 8
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    output logic [LANE_W-1:0] y,
    output logic              zero
);

    // Bitwise AND. X/Z propagate with the usual & rules (0 & X = 0).
    always_comb begin
        y    = a & b;
        zero = (y == '0);
    end

endmodule

module and_32bit #(
    parameter int WIDTH  = 32,
    parameter int LANE_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] Ra,
    input  logic [WIDTH-1:0] Rb,
    input  logic             en,
    output logic [WIDTH-1:0] Rz,
    output logic [WIDTH-1:0] Rz_q,
    output logic             valid_q,
    output logic             zero_q
);

    localparam int NUM_LANES = WIDTH / LANE_W;

    logic [NUM_LANES-1:0][LANE_W-1:0] rz_lane;
    logic [NUM_LANES-1:0]             lane_zero;
    logic                             rz_zero;

    // One lane instance per LANE_W-bit slice of the operands.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        and_lane #(
            .LANE_W (LANE_W)
        ) u_lane (
            .a    (Ra[l*LANE_W +: LANE_W]),
            .b    (Rb[l*LANE_W +: LANE_W]),
            .y    (rz_lane[l]),
            .zero (lane_zero[l])
        );
    end

    // Reassemble the lanes into the full-width result.
    // The full result is zero only if every lane reports zero.
    always_comb begin
        Rz      = rz_lane;
        rz_zero = &lane_zero;
    end

    // Registered copy. clr wins at any time, so an edge where clr is still
    // high never captures, even with en=1. The cleared state reads as
    // "result 0, not valid", which is why zero_q resets to 1.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            Rz_q    <= '0;
            valid_q <= 1'b0;
            zero_q  <= 1'b1;
        end else if (en) begin
            Rz_q    <= Rz;
            valid_q <= 1'b1;
            zero_q  <= rz_zero;
        end
    end

endmodule

// File: tb/tb_and_32bit.sv
// Directed-vector bench for and_32bit.
// Every expected value below is hand-computed.

module tb_and_32bit;

    logic        clk;
    logic        clr;
    logic [31:0] Ra;
    logic [31:0] Rb;
    logic        en;
    logic [31:0] Rz;
    logic [31:0] Rz_q;
    logic        valid_q;
    logic        zero_q;

    int n_cmp;
    int n_err;

    and_32bit dut (
        .clk     (clk),
        .clr     (clr),
        .Ra      (Ra),
        .Rb      (Rb),
        .en      (en),
        .Rz      (Rz),
        .Rz_q    (Rz_q),
        .valid_q (valid_q),
        .zero_q  (zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Combinational vectors: {Ra, Rb, expected Rz}.
    logic [31:0] vec [6][3];

    initial begin
        n_cmp = 0;
        n_err = 0;
        vec[0] = '{32'h00000000, 32'h00000000, 32'h00000000};
        vec[1] = '{32'h00000000, 32'hABCD1234, 32'h00000000};
        vec[2] = '{32'hAAAAAAAA, 32'h55555555, 32'h00000000};
        vec[3] = '{32'hFFFFFFFF, 32'hABCD1234, 32'hABCD1234};
        vec[4] = '{32'h00000037, 32'h00000073, 32'h00000033};
        vec[5] = '{32'hF0F0FF00, 32'h3C3C0FF0, 32'h30300F00};

        // Reset state.
        clr = 1'b1; en = 1'b0; Ra = '0; Rb = '0;
        tick(); tick();
        chk("rst_rz_q",  Rz_q, 32'h0);
        chk("rst_valid", {31'b0, valid_q}, 32'h0);
        chk("rst_zero",  {31'b0, zero_q},  32'h1);

        // clr held high through an edge with en=1: no capture, but Rz still works.
        en = 1'b1; Ra = 32'h37; Rb = 32'h73;
        tick();
        chk("clr_hold_rz_q",  Rz_q, 32'h0);
        chk("clr_hold_valid", {31'b0, valid_q}, 32'h0);
        chk("clr_rz",         Rz, 32'h33);

        // Release clr with en=0: the registered path must keep holding.
        clr = 1'b0; en = 1'b0;
        tick();
        chk("en0_rz_q",  Rz_q, 32'h0);
        chk("en0_valid", {31'b0, valid_q}, 32'h0);

        // Combinational vectors.
        for (int i = 0; i < 6; i++) begin
            Ra = vec[i][0]; Rb = vec[i][1];
            #1;
            chk($sformatf("vec%0d_rz", i), Rz, vec[i][2]);
        end

        // Single capture.
        Ra = 32'h37; Rb = 32'h73; en = 1'b1;
        tick();
        chk("cap_rz_q",  Rz_q, 32'h33);
        chk("cap_valid", {31'b0, valid_q}, 32'h1);
        chk("cap_zero",  {31'b0, zero_q},  32'h0);

        // Hold with en=0 while the operands change.
        en = 1'b0; Ra = 32'hFFFFFFFF; Rb = 32'hABCD1234;
        tick();
        chk("hold_rz_q", Rz_q, 32'h33);
        chk("hold_rz",   Rz, 32'hABCD1234);

        // Back-to-back captures, the second one with a zero result.
        en = 1'b1;
        tick();
        chk("b2b0_rz_q", Rz_q, 32'hABCD1234);
        Ra = 32'hAAAAAAAA; Rb = 32'h55555555;
        tick();
        chk("b2b1_rz_q",  Rz_q, 32'h0);
        chk("b2b1_valid", {31'b0, valid_q}, 32'h1);
        chk("b2b1_zero",  {31'b0, zero_q},  32'h1);

        // Capture again, then pulse clr mid-cycle: the clear is asynchronous.
        Ra = 32'h37; Rb = 32'h73;
        tick();
        chk("pre_clr_rz_q", Rz_q, 32'h33);
        en = 1'b0;
        #2 clr = 1'b1;
        #1;
        chk("aclr_rz_q",  Rz_q, 32'h0);
        chk("aclr_valid", {31'b0, valid_q}, 32'h0);
        chk("aclr_zero",  {31'b0, zero_q},  32'h1);
        chk("aclr_rz",    Rz, 32'h33);
        #1 clr = 1'b0;

        // X propagation: 0 & X = 0, 1 & X = X.
        Ra = 32'h00000000; Rb = 'x;
        #1;
        chk("x_zero_rz", Rz, 32'h0);
        Ra = 32'hFFFF0000;
        #1;
        chk("x_mix_rz", Rz, {{16{1'bx}}, 16'h0000});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Safety bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
